// File: rtl/lcd_wave_render_if.sv
// Bus between lcd_wave_render and its surroundings: the sample capture side and
// the lcd_driver pixel request side.
interface lcd_wave_render_if;
  logic        sample_valid;
  logic [7:0]  sample_data;
  logic        cap_start;
  logic        cap_busy;
  logic        cap_done;
  logic        data_req;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic [23:0] pixel_data;

  modport master (
    output sample_valid, sample_data, cap_start, data_req, pixel_xpos, pixel_ypos,
    input  cap_busy, cap_done, pixel_data
  );

  // data_req is only timing information for the driver; the renderer produces a pixel every cycle.
  modport slave (
    input  sample_valid, sample_data, cap_start, pixel_xpos, pixel_ypos,
    output cap_busy, cap_done, pixel_data
  );
endinterface

// File: rtl/lcd_wave_render.sv
// Oscilloscope trace renderer: captures a sample record into the back bank of a
// two-bank line store and draws the front bank as a trace over a grid, 1-cycle latency.
module lcd_wave_render #(
  parameter int          H_POINTS   = 800,
  parameter logic [10:0] WAVE_TOP   = 11'd112,
  parameter int          GRID_DIV   = 50,
  parameter logic [23:0] COLOR_BG   = 24'h000000,
  parameter logic [23:0] COLOR_GRID = 24'h404040,
  parameter logic [23:0] COLOR_WAVE = 24'hFFFF00
) (
  input  logic             lcd_pclk,
  input  logic             rst_n,
  lcd_wave_render_if.slave bus
);

  localparam int              AW        = $clog2(H_POINTS);
  localparam int              GW        = $clog2(GRID_DIV);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(H_POINTS - 1);
  localparam logic [10:0]     H_LIMIT   = 11'(H_POINTS);
  localparam logic [GW-1:0]   GRID_LAST = GW'(GRID_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic            disp_bank_q, disp_bank_d;
  logic            wave_valid_q, wave_valid_d;
  logic            cap_done_q, cap_done_d;
  logic [10:0]     xpos_q, ypos_q;
  logic [GW-1:0]   gx_q, gx_d, gy_q, gy_d;
  logic            live_q;
  logic [7:0]      rd_q, prev_q;
  logic [7:0]      mem_q [2][H_POINTS];

  logic            frame_end_s, wr_en_s, wr_last_s;
  logic [AW-1:0]   rd_addr_s;
  logic [7:0]      s_prev_s;
  logic [10:0]     r_cur_s, r_prev_s, r_lo_s, r_hi_s;
  logic            hit_s, grid_s;
  logic [23:0]     colour_s;

  // Screen row of a sample value; 11 bits holds WAVE_TOP + 255 without overflow.
  function automatic logic [10:0] row_of(input logic [7:0] s);
    return WAVE_TOP + 11'd255 - {3'b000, s};
  endfunction

  assign frame_end_s = (bus.pixel_ypos == 11'd0) && (ypos_q != 11'd0);
  assign wr_en_s     = (state_q == ST_FILL) && bus.sample_valid;
  assign wr_last_s   = wr_en_s && (wr_addr_q == LAST_ADDR);
  assign rd_addr_s   = (bus.pixel_xpos < H_LIMIT) ? bus.pixel_xpos[AW-1:0] : '0;

  // Capture FSM state register.
  always_ff @(posedge lcd_pclk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture FSM next state; a frame_end coinciding with the last write is too early to swap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.cap_start) state_d = ST_FILL; else state_d = ST_IDLE;
      ST_FILL: if (wr_last_s)     state_d = ST_PEND; else state_d = ST_FILL;
      ST_PEND: if (frame_end_s)   state_d = ST_IDLE; else state_d = ST_PEND;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture FSM outputs: write pointer, bank swap, completion pulse.
  always_comb begin
    wr_addr_d    = wr_addr_q;
    disp_bank_d  = disp_bank_q;
    wave_valid_d = wave_valid_q;
    cap_done_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.cap_start) wr_addr_d = '0; else wr_addr_d = wr_addr_q;
      ST_FILL: if (bus.sample_valid) wr_addr_d = wr_addr_q + AW'(1); else wr_addr_d = wr_addr_q;
      ST_PEND: begin
        if (frame_end_s) begin
          disp_bank_d  = ~disp_bank_q;
          wave_valid_d = 1'b1;
          cap_done_d   = 1'b1;
        end else begin
          cap_done_d   = 1'b0;
        end
      end
      default: cap_done_d = 1'b0;
    endcase
  end

  // Grid wrap counters track xpos mod GRID_DIV and ypos mod GRID_DIV without division.
  always_comb begin
    if (bus.pixel_xpos == 11'd0)          gx_d = '0;
    else if (bus.pixel_xpos != xpos_q)    gx_d = (gx_q == GRID_LAST) ? '0 : gx_q + GW'(1);
    else                                  gx_d = gx_q;
    if (bus.pixel_ypos == 11'd0)          gy_d = '0;
    else if (bus.pixel_ypos != ypos_q)    gy_d = (gy_q == GRID_LAST) ? '0 : gy_q + GW'(1);
    else                                  gy_d = gy_q;
  end

  // Control and pipeline registers.
  always_ff @(posedge lcd_pclk) begin
    if (!rst_n) begin
      wr_addr_q    <= '0;
      disp_bank_q  <= 1'b0;
      wave_valid_q <= 1'b0;
      cap_done_q   <= 1'b0;
      xpos_q       <= 11'd0;
      ypos_q       <= 11'd0;
      gx_q         <= '0;
      gy_q         <= '0;
      live_q       <= 1'b0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      disp_bank_q  <= disp_bank_d;
      wave_valid_q <= wave_valid_d;
      cap_done_q   <= cap_done_d;
      xpos_q       <= bus.pixel_xpos;
      ypos_q       <= bus.pixel_ypos;
      gx_q         <= gx_d;
      gy_q         <= gy_d;
      live_q       <= 1'b1;
    end
  end

  // Line store: capture writes the back bank, render reads the front bank synchronously.
  always_ff @(posedge lcd_pclk) begin
    if (wr_en_s) mem_q[~disp_bank_q][wr_addr_q] <= bus.sample_data;
    rd_q   <= mem_q[disp_bank_q][rd_addr_s];
    prev_q <= rd_q;
  end

  // Colour mux on the RAM output and the registered coordinates.
  always_comb begin
    s_prev_s = (xpos_q == 11'd0) ? rd_q : prev_q;
    r_cur_s  = row_of(rd_q);
    r_prev_s = row_of(s_prev_s);
    if (r_cur_s < r_prev_s) begin
      r_lo_s = r_cur_s;
      r_hi_s = r_prev_s;
    end else begin
      r_lo_s = r_prev_s;
      r_hi_s = r_cur_s;
    end
    hit_s  = wave_valid_q && (xpos_q < H_LIMIT) && (ypos_q >= r_lo_s) && (ypos_q <= r_hi_s);
    grid_s = (gx_q == '0) || (gy_q == '0);
    if (!live_q)     colour_s = 24'h000000;
    else if (hit_s)  colour_s = COLOR_WAVE;
    else if (grid_s) colour_s = COLOR_GRID;
    else             colour_s = COLOR_BG;
  end

  assign bus.pixel_data = colour_s;
  assign bus.cap_busy   = (state_q == ST_FILL) || (state_q == ST_PEND);
  assign bus.cap_done   = cap_done_q;

endmodule

// File: tb/tb_lcd_wave_render.sv
// Scoreboard bench for lcd_wave_render: a frame driver pushes expected pixels,
// a monitor pops and compares them one cycle later when lcd_de is high.
module tb_lcd_wave_render;
  localparam logic [23:0] C_BG   = 24'h000000;
  localparam logic [23:0] C_GRID = 24'h404040;
  localparam logic [23:0] C_WAVE = 24'hFFFF00;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] pix;
  } exp_t;

  logic clk;
  logic rst_n;
  lcd_wave_render_if bus ();

  lcd_wave_render dut (
    .lcd_pclk (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          done_cnt     = 0;
  exp_t        exp_q[$];
  logic [23:0] obs [int];
  logic        de_r = 1'b0;

  logic [7:0] disp_m [800];
  logic [7:0] back_m [800];
  bit         wv_m   = 1'b0;
  bit         pend_m = 1'b0;

  // Reference pixel from the bench's own copy of the displayed record.
  function automatic logic [23:0] exp_pix(input int x, input int y);
    int rc, rp;
    bit hit, grid;
    hit = 1'b0;
    if (wv_m && x < 800) begin
      rc = 367 - int'(disp_m[x]);
      if (x == 0) rp = rc;
      else        rp = 367 - int'(disp_m[x-1]);
      hit = (y >= ((rc < rp) ? rc : rp)) && (y <= ((rc < rp) ? rp : rc));
    end
    grid = (x % 50 == 0) || (y % 50 == 0);
    if (hit)       return C_WAVE;
    else if (grid) return C_GRID;
    else           return C_BG;
  endfunction

  always @(posedge clk) de_r <= bus.data_req;

  // Monitor: one expected pixel per lcd_de cycle.
  always @(negedge clk) begin
    exp_t e;
    if (bus.cap_done === 1'b1) done_cnt++;
    if (de_r) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL pixel_unexpected: got %h with no expected entry", bus.pixel_data);
      end else begin
        e = exp_q.pop_front();
        obs[e.x * 2048 + e.y] = bus.pixel_data;
        if (bus.pixel_data !== e.pix) begin
          tests_failed++;
          $display("FAIL pixel(x=%0d,y=%0d): got %h expected %h", e.x, e.y, bus.pixel_data, e.pix);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Spot check of a pixel seen in the last frame; eq=0 means "must differ from e".
  task automatic spot(input string name, input int x, input int y, input logic [23:0] e, input bit eq);
    int key;
    key = x * 2048 + y;
    tests_run++;
    if (!obs.exists(key)) begin
      tests_failed++;
      $display("FAIL %s: pixel (%0d,%0d) never displayed, required %s%h", name, x, y, eq ? "" : "not ", e);
    end else if (eq ? (obs[key] !== e) : (obs[key] === e)) begin
      tests_failed++;
      $display("FAIL %s: got %h required %s%h", name, obs[key], eq ? "" : "not ", e);
    end
  endtask

  task automatic drive_px(input int x, input int y, input bit req);
    bus.pixel_xpos = 11'(x);
    bus.pixel_ypos = 11'(y);
    bus.data_req   = req;
    if (req) exp_q.push_back('{x: x, y: y, pix: exp_pix(x, y)});
    step();
  endtask

  // One frame: rows 1..nrows of ncols pixels (row wide_row spans 0..1023), then vertical blanking.
  task automatic run_frame(input int nrows, input int ncols, input int wide_row);
    int cols;
    obs.delete();
    for (int y = 1; y <= nrows; y++) begin
      cols = (y == wide_row) ? 1024 : ncols;
      for (int x = 0; x < cols; x++) drive_px(x, y, 1'b1);
      drive_px(0, y, 1'b0);
    end
    if (pend_m) begin
      disp_m = back_m;
      wv_m   = 1'b1;
      pend_m = 1'b0;
    end
    for (int i = 0; i < 3; i++) drive_px(0, 0, 1'b0);
  endtask

  task automatic pulse_start();
    bus.cap_start = 1'b1;
    step();
    bus.cap_start = 1'b0;
  endtask

  // Kind 0: ramp, 1: 0 below column 100 and 255 from there, 2: falling ramp.
  task automatic feed(input int kind, input int n, input int extra_start_at);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      case (kind)
        0:       v = 8'(i % 256);
        1:       v = (i < 100) ? 8'd0 : 8'd255;
        default: v = 8'(255 - (i % 256));
      endcase
      back_m[i]        = v;
      bus.sample_valid = 1'b1;
      bus.sample_data  = v;
      bus.cap_start    = (i == extra_start_at);
      step();
    end
    bus.sample_valid = 1'b0;
    bus.cap_start    = 1'b0;
    if (n == 800) pend_m = 1'b1;
  endtask

  initial begin
    int d0;
    rst_n            = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = 8'd0;
    bus.cap_start    = 1'b0;
    bus.data_req     = 1'b0;
    bus.pixel_xpos   = 11'd0;
    bus.pixel_ypos   = 11'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pixel_data", 32'(bus.pixel_data), 32'h0);
    chk("reset_cap_busy", 32'(bus.cap_busy), 32'h0);
    chk("reset_cap_done", 32'(bus.cap_done), 32'h0);
    rst_n = 1'b1;
    step();

    // No capture yet: grid and background only.
    run_frame(8, 8, 0);
    run_frame(100, 8, 0);
    spot("idle_grid_0_100", 0, 100, C_GRID, 1'b1);
    spot("idle_bg_7_7", 7, 7, C_BG, 1'b1);
    chk("idle_no_done", 32'(done_cnt), 32'd0);

    // Ramp capture: busy through FILL and PEND, one cap_done at the swap.
    pulse_start();
    chk("ramp_busy_fill", 32'(bus.cap_busy), 32'h1);
    feed(0, 800, -1);
    chk("ramp_busy_pend", 32'(bus.cap_busy), 32'h1);
    chk("ramp_no_done_yet", 32'(done_cnt), 32'd0);
    run_frame(4, 4, 0);
    chk("ramp_done_once", 32'(done_cnt), 32'd1);
    chk("ramp_busy_after", 32'(bus.cap_busy), 32'h0);
    run_frame(360, 12, 0);
    spot("ramp_wave_10_357", 10, 357, C_WAVE, 1'b1);
    spot("ramp_wave_10_358", 10, 358, C_WAVE, 1'b1);
    spot("ramp_bg_10_356", 10, 356, C_BG, 1'b1);
    chk("ramp_done_stable", 32'(done_cnt), 32'd1);

    // Step record, plus a full-width row 112 for the x>=800 cut-off.
    pulse_start();
    feed(1, 800, -1);
    run_frame(4, 4, 0);
    run_frame(370, 102, 112);
    spot("step_c100_y112", 100, 112, C_WAVE, 1'b1);
    spot("step_c100_y367", 100, 367, C_WAVE, 1'b1);
    spot("step_c100_y111", 100, 111, C_WAVE, 1'b0);
    spot("step_c100_y368", 100, 368, C_WAVE, 1'b0);
    spot("step_c99_y367", 99, 367, C_WAVE, 1'b1);
    spot("step_c99_y366", 99, 366, C_WAVE, 1'b0);
    spot("wide_799_112", 799, 112, C_WAVE, 1'b1);
    spot("wide_800_112", 800, 112, C_GRID, 1'b1);
    spot("wide_900_112", 900, 112, C_GRID, 1'b1);
    spot("wide_1023_112", 1023, 112, C_BG, 1'b1);
    chk("step_done_count", 32'(done_cnt), 32'd2);

    // Capture completing mid-frame with a stray cap_start: old trace holds until frame_end.
    d0 = done_cnt;
    pulse_start();
    fork
      feed(0, 800, 400);
      run_frame(370, 12, 0);
    join
    spot("mid_old_5_367", 5, 367, C_WAVE, 1'b1);
    spot("mid_old_5_362", 5, 362, C_WAVE, 1'b0);
    chk("mid_done_once", 32'(done_cnt), 32'(d0 + 1));
    chk("mid_busy_after", 32'(bus.cap_busy), 32'h0);
    run_frame(370, 12, 0);
    spot("mid_new_5_362", 5, 362, C_WAVE, 1'b1);
    spot("mid_new_5_367", 5, 367, C_WAVE, 1'b0);
    chk("mid_no_extra_done", 32'(done_cnt), 32'(d0 + 1));
    chk("mid_no_extra_busy", 32'(bus.cap_busy), 32'h0);

    // Reset during FILL discards the partial record and hides the trace.
    pulse_start();
    feed(2, 400, -1);
    chk("rst_busy_before", 32'(bus.cap_busy), 32'h1);
    rst_n = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(bus.cap_busy), 32'h0);
    chk("rst_done", 32'(bus.cap_done), 32'h0);
    chk("rst_pixel", 32'(bus.pixel_data), 32'h0);
    rst_n  = 1'b1;
    wv_m   = 1'b0;
    pend_m = 1'b0;
    step();
    d0 = done_cnt;
    run_frame(368, 12, 0);
    spot("rst_no_wave_10_357", 10, 357, C_WAVE, 1'b0);
    chk("rst_no_done", 32'(done_cnt), 32'(d0));
    pulse_start();
    feed(2, 800, -1);
    run_frame(4, 4, 0);
    run_frame(130, 12, 0);
    spot("fresh_10_122", 10, 122, C_WAVE, 1'b1);
    spot("fresh_10_121", 10, 121, C_WAVE, 1'b1);
    spot("fresh_10_123", 10, 123, C_WAVE, 1'b0);
    chk("fresh_done_once", 32'(done_cnt), 32'(d0 + 1));

    repeat (2) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
